output_buffer_bank: RTL and testbench
=====================================

Name: output_buffer_bank

Overview:
- Write-side counterpart to the input line buffer. Collects wavefront-skewed results from the systolic array's BANK_WIDTH output columns and serialises them in raster order into the output feature-map SRAM.
- Column i delivers its result for a row roughly i cycles after column 0. Each column has a small FIFO that absorbs this skew.
- A drain FSM writes one word per cycle to SRAM: column 0..W-1, row by row, from a configurable base address.

Parameters:
- BANK_WIDTH, 32: physical number of output columns; hardware maximum is 1920.
- DATA_W, 32: result word width.
- SRAM_ADDR_W, 16: output SRAM address width.
- COL_FIFO_DEPTH, 4: entries per column FIFO; power of 2, at least 2.

Ports:
- clk_i  in  1  clock.
- rst_sync_i  in  1  synchronous reset, active-high.
- start_i  in  1  1-cycle pulse; latches config, begins a frame.
- cfg_out_w_i  in  32  output row width W, range 1..BANK_WIDTH.
- cfg_out_h_i  in  32  output row count H, at least 1.
- cfg_base_addr_i  in  SRAM_ADDR_W  SRAM address of pixel (0,0).
- push_i  in  BANK_WIDTH  per-column result-valid strobes.
- data_in_i  in  BANK_WIDTH x DATA_W  per-column result data.
- ob_ready_o  out  1  every column FIFO in [0,W) has at least 1 free entry.
- sram_wr_en_o  out  1  SRAM write strobe.
- sram_wr_addr_o  out  SRAM_ADDR_W  SRAM write address.
- sram_wr_data_o  out  DATA_W  SRAM write data.
- row_done_o  out  1  1-cycle pulse with the write of column W-1 of each row.
- frame_done_o  out  1  1-cycle pulse with the final write of the frame.
- busy_o  out  1  high in any state other than IDLE.
- overflow_o  out  1  sticky flag: a push was dropped because its FIFO was full.

Behaviour:
- Reset: all outputs are 0, FIFOs are empty, state is IDLE, all counters and latched config are 0. Reset asserted mid-frame aborts immediately with no further writes.
- FSM states: IDLE, DRAIN, FLUSH.
  - IDLE -> DRAIN on start_i when W>=1 and H>=1. This latches W, H and base address, clears the FIFOs and counters, and clears overflow_o.
  - start_i is ignored outside IDLE, and ignored in IDLE when W==0 or H==0.
  - DRAIN -> FLUSH when the final word (row H-1, column W-1) is popped.
  - FLUSH -> IDLE on the next cycle.
- Push: push_i[i] with i<W writes data_in_i[i] into FIFO i on the clock edge.
  - Pushes to columns i>=W are ignored.
  - Pushes in IDLE are ignored.
- Full column: a push to a full FIFO is dropped and sets overflow_o. Exception: if that column is popped in the same cycle, the push is accepted (simultaneous push/pop on a full FIFO).
- Pop: in DRAIN, FIFO col_cnt is popped when non-empty, at most one column per cycle. If it is empty, the FSM stalls on that column and pops no other column.
- Write timing:
  - Registered outputs go high the cycle after the pop: sram_wr_en_o=1, sram_wr_data_o = popped word, sram_wr_addr_o = addr_cnt.
  - Minimum latency from push to sram_wr_en_o is 2 cycles.
  - sram_wr_en_o is 0 on every non-write cycle. Data and address hold their last values.
- Counters:
  - addr_cnt starts at base and increments by 1 per write, wrapping modulo 2^SRAM_ADDR_W.
  - col_cnt runs 0..W-1 and wraps to 0, incrementing row_cnt.
  - Width compares use 32-bit zero extension.
- row_done_o and frame_done_o are registered and aligned with the corresponding sram_wr_en_o cycle. On the final write both pulse.
- ob_ready_o is combinational from FIFO counts. It is 0 in IDLE. The producer must hold its wavefront until ob_ready_o=1.
- Data from a previous row never mixes into the next row: each FIFO is in-order per column.

Optional Feature:
- Macro OB_RELU_EN.
  - Defined: sram_wr_data_o is max(0, signed word), so a negative value writes 0. Applied on the write register, with no added latency.
  - Undefined: data is passed through unmodified.

Test Plan:
- W=4, H=2, base=0x100; skewed pushes (col i at cycle t0+i) of values 10+i and 20+i -> writes 10,11,12,13 to 0x100..0x103, then 20..23 to 0x104..0x107; row_done_o pulses twice; frame_done_o pulses on the 0x107 write; busy_o falls after FLUSH.
- W=3, col 0 pushes 3 rows before col 1 pushes anything -> FSM stalls at col 1 with no writes; then cols 1 and 2 push -> raster order is preserved.
- COL_FIFO_DEPTH=4; 5 pushes to col 2 while drain is stalled at col 0 -> overflow_o=1 and stays 1 until the next start_i. A push to a full FIFO in the same cycle as its pop is accepted with no overflow.
- W=2; push_i[5] asserted -> ignored, no write. start_i mid-frame -> ignored. W=0 on start_i -> FSM stays in IDLE.
- rst_sync_i asserted mid-row -> next cycle all outputs are 0, FSM is IDLE, FIFOs are empty; a new frame then completes correctly.
- OB_RELU_EN defined; push values -5 and 7 -> writes 0 and 7. Undefined -> writes 0xFFFFFFFB and 7.

Source files
------------

// File: rtl/output_buffer_bank.sv
// rtl/output_buffer_bank.sv - skew-absorbing per-column FIFOs drained in raster order to SRAM (optional OB_RELU_EN)
module output_buffer_bank #(
    parameter int BANK_WIDTH     = 32,
    parameter int DATA_W         = 32,
    parameter int SRAM_ADDR_W    = 16,
    parameter int COL_FIFO_DEPTH = 4
) (
    input  logic                         clk_i,
    input  logic                         rst_sync_i,
    input  logic                         start_i,
    input  logic [31:0]                  cfg_out_w_i,
    input  logic [31:0]                  cfg_out_h_i,
    input  logic [SRAM_ADDR_W-1:0]       cfg_base_addr_i,
    input  logic [BANK_WIDTH-1:0]        push_i,
    input  logic [BANK_WIDTH*DATA_W-1:0] data_in_i,
    output logic                         ob_ready_o,
    output logic                         sram_wr_en_o,
    output logic [SRAM_ADDR_W-1:0]       sram_wr_addr_o,
    output logic [DATA_W-1:0]            sram_wr_data_o,
    output logic                         row_done_o,
    output logic                         frame_done_o,
    output logic                         busy_o,
    output logic                         overflow_o
);

    localparam int PTR_W = $clog2(COL_FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int IDX_W = (BANK_WIDTH > 1) ? $clog2(BANK_WIDTH) : 1;

    typedef enum logic [1:0] {ST_IDLE, ST_DRAIN, ST_FLUSH} state_t;

    state_t                  r_state;
    state_t                  w_state_next;

    logic [DATA_W-1:0]       r_mem  [BANK_WIDTH][COL_FIFO_DEPTH];
    logic [PTR_W-1:0]        r_wptr [BANK_WIDTH];
    logic [PTR_W-1:0]        r_rptr [BANK_WIDTH];
    logic [CNT_W-1:0]        r_cnt  [BANK_WIDTH];

    logic [31:0]             r_cfg_w;
    logic [31:0]             r_cfg_h;
    logic [31:0]             r_col_cnt;
    logic [31:0]             r_row_cnt;
    logic [SRAM_ADDR_W-1:0]  r_addr_cnt;

    logic                    r_wr_en;
    logic [SRAM_ADDR_W-1:0]  r_wr_addr;
    logic [DATA_W-1:0]       r_wr_data;
    logic                    r_row_done;
    logic                    r_frame_done;
    logic                    r_overflow;

    logic                    w_start;
    logic [IDX_W-1:0]        w_col_idx;
    logic                    w_pop;
    logic                    w_row_end;
    logic                    w_last;
    logic [DATA_W-1:0]       w_head_data;
    logic [DATA_W-1:0]       w_wr_word;
    logic                    w_ready;
    logic [BANK_WIDTH-1:0]   w_push_req;
    logic [BANK_WIDTH-1:0]   w_push_acc;
    logic [BANK_WIDTH-1:0]   w_push_drop;
    logic [BANK_WIDTH-1:0]   w_pop_col;

    assign w_start     = start_i && (r_state == ST_IDLE) &&
                         (cfg_out_w_i != 32'd0) && (cfg_out_h_i != 32'd0);
    assign w_col_idx   = r_col_cnt[IDX_W-1:0];
    assign w_pop       = (r_state == ST_DRAIN) && (r_cnt[w_col_idx] != '0);
    assign w_row_end   = (r_col_cnt == r_cfg_w - 32'd1);
    assign w_last      = w_row_end && (r_row_cnt == r_cfg_h - 32'd1);
    assign w_head_data = r_mem[w_col_idx][r_rptr[w_col_idx]];

`ifdef OB_RELU_EN
    assign w_wr_word = w_head_data[DATA_W-1] ? '0 : w_head_data;
`else
    assign w_wr_word = w_head_data;
`endif

    // Per-column push acceptance; a full FIFO still takes a push when it is popped this cycle
    always_comb begin
        w_push_req  = '0;
        w_push_acc  = '0;
        w_push_drop = '0;
        w_pop_col   = '0;
        w_ready     = (r_state != ST_IDLE);
        for (int i = 0; i < BANK_WIDTH; i++) begin
            w_pop_col[i]   = w_pop && (w_col_idx == IDX_W'(i));
            w_push_req[i]  = push_i[i] && (r_state != ST_IDLE) && (32'(i) < r_cfg_w);
            w_push_acc[i]  = w_push_req[i] &&
                             ((r_cnt[i] != CNT_W'(COL_FIFO_DEPTH)) || w_pop_col[i]);
            w_push_drop[i] = w_push_req[i] && !w_push_acc[i];
            if ((32'(i) < r_cfg_w) && (r_cnt[i] == CNT_W'(COL_FIFO_DEPTH))) begin
                w_ready = 1'b0;
            end
        end
    end

    // FIFO pointers and occupancy; emptied on reset and at every accepted start
    always_ff @(posedge clk_i) begin
        if (rst_sync_i || w_start) begin
            for (int i = 0; i < BANK_WIDTH; i++) begin
                r_wptr[i] <= '0;
                r_rptr[i] <= '0;
                r_cnt[i]  <= '0;
            end
        end else begin
            for (int i = 0; i < BANK_WIDTH; i++) begin
                if (w_push_acc[i]) r_wptr[i] <= r_wptr[i] + PTR_W'(1);
                if (w_pop_col[i])  r_rptr[i] <= r_rptr[i] + PTR_W'(1);
                r_cnt[i] <= r_cnt[i] + CNT_W'(w_push_acc[i]) - CNT_W'(w_pop_col[i]);
            end
        end
    end

    // FIFO storage; contents are only meaningful below the occupancy count
    always_ff @(posedge clk_i) begin
        for (int i = 0; i < BANK_WIDTH; i++) begin
            if (w_push_acc[i]) r_mem[i][r_wptr[i]] <= data_in_i[i*DATA_W +: DATA_W];
        end
    end

    // Drain FSM state register
    always_ff @(posedge clk_i) begin
        if (rst_sync_i) r_state <= ST_IDLE;
        else            r_state <= w_state_next;
    end

    // Drain FSM next state
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE:  if (w_start) w_state_next = ST_DRAIN;
            ST_DRAIN: if (w_pop && w_last) w_state_next = ST_FLUSH;
            ST_FLUSH: w_state_next = ST_IDLE;
            default:  w_state_next = ST_IDLE;
        endcase
    end

    // Frame configuration and raster position counters
    always_ff @(posedge clk_i) begin
        if (rst_sync_i) begin
            r_cfg_w    <= '0;
            r_cfg_h    <= '0;
            r_col_cnt  <= '0;
            r_row_cnt  <= '0;
            r_addr_cnt <= '0;
        end else if (w_start) begin
            r_cfg_w    <= cfg_out_w_i;
            r_cfg_h    <= cfg_out_h_i;
            r_col_cnt  <= '0;
            r_row_cnt  <= '0;
            r_addr_cnt <= cfg_base_addr_i;
        end else if (w_pop) begin
            r_addr_cnt <= r_addr_cnt + SRAM_ADDR_W'(1);
            if (w_row_end) begin
                r_col_cnt <= '0;
                r_row_cnt <= r_row_cnt + 32'd1;
            end else begin
                r_col_cnt <= r_col_cnt + 32'd1;
            end
        end
    end

    // SRAM write register, row/frame markers and sticky overflow
    always_ff @(posedge clk_i) begin
        if (rst_sync_i) begin
            r_wr_en      <= 1'b0;
            r_wr_addr    <= '0;
            r_wr_data    <= '0;
            r_row_done   <= 1'b0;
            r_frame_done <= 1'b0;
            r_overflow   <= 1'b0;
        end else begin
            r_wr_en      <= w_pop;
            r_row_done   <= w_pop && w_row_end;
            r_frame_done <= w_pop && w_last;
            if (w_pop) begin
                r_wr_addr <= r_addr_cnt;
                r_wr_data <= w_wr_word;
            end
            if (w_start)          r_overflow <= 1'b0;
            else if (|w_push_drop) r_overflow <= 1'b1;
        end
    end

    assign ob_ready_o     = w_ready;
    assign sram_wr_en_o   = r_wr_en;
    assign sram_wr_addr_o = r_wr_addr;
    assign sram_wr_data_o = r_wr_data;
    assign row_done_o     = r_row_done;
    assign frame_done_o   = r_frame_done;
    assign busy_o         = (r_state != ST_IDLE);
    assign overflow_o     = r_overflow;

endmodule

// File: tb/tb_output_buffer_bank.sv
// tb/tb_output_buffer_bank.sv - scoreboard bench for output_buffer_bank
module tb_output_buffer_bank;

    localparam int BW = 8;
    localparam int DW = 32;
    localparam int AW = 16;
    localparam int D  = 4;

    logic              clk = 1'b0;
    logic              rst;
    logic              start;
    logic [31:0]       cfg_w;
    logic [31:0]       cfg_h;
    logic [AW-1:0]     cfg_base;
    logic [BW-1:0]     push;
    logic [BW*DW-1:0]  din;
    logic              ob_ready;
    logic              wr_en;
    logic [AW-1:0]     wr_addr;
    logic [DW-1:0]     wr_data;
    logic              row_done;
    logic              frame_done;
    logic              busy;
    logic              overflow;

    typedef struct {
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
        logic          rd;
        logic          fd;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   errors = 0;
    int   checks = 0;
    int   n_wr   = 0;
    int   wr_mark;

    always #5 clk = ~clk;

    output_buffer_bank #(
        .BANK_WIDTH(BW), .DATA_W(DW), .SRAM_ADDR_W(AW), .COL_FIFO_DEPTH(D)
    ) dut (
        .clk_i(clk), .rst_sync_i(rst), .start_i(start),
        .cfg_out_w_i(cfg_w), .cfg_out_h_i(cfg_h), .cfg_base_addr_i(cfg_base),
        .push_i(push), .data_in_i(din), .ob_ready_o(ob_ready),
        .sram_wr_en_o(wr_en), .sram_wr_addr_o(wr_addr), .sram_wr_data_o(wr_data),
        .row_done_o(row_done), .frame_done_o(frame_done),
        .busy_o(busy), .overflow_o(overflow)
    );

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_wr(input logic [AW-1:0] a, input logic [DW-1:0] d,
                             input logic rd, input logic fd);
        exp_t e;
        e.addr = a; e.data = d; e.rd = rd; e.fd = fd;
        exp_q.push_back(e);
    endtask

    task automatic set_col(input int c, input logic [DW-1:0] v);
        push[c] = 1'b1;
        din[c*DW +: DW] = v;
    endtask

    task automatic fire();
        tick();
        push = '0;
    endtask

    task automatic do_start(input logic [31:0] w, input logic [31:0] h, input logic [AW-1:0] b);
        cfg_w = w; cfg_h = h; cfg_base = b; start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_idle(input string nm);
        int t = 0;
        while (busy && t < 200) begin
            tick();
            t++;
        end
        check(nm, busy, 0);
        check({nm, "_queue_empty"}, exp_q.size(), 0);
    endtask

    // Monitor: every SRAM write is matched against the head of the scoreboard
    always @(negedge clk) begin
        if (!rst && wr_en) begin
            n_wr++;
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_write: got addr %0h data %0h expected no write", wr_addr, wr_data);
            end else begin
                mon_e = exp_q.pop_front();
                check("wr_addr", wr_addr, mon_e.addr);
                check("wr_data", wr_data, mon_e.data);
                check("row_done", row_done, mon_e.rd);
                check("frame_done", frame_done, mon_e.fd);
            end
        end else if (!rst && (row_done || frame_done)) begin
            checks++;
            errors++;
            $display("FAIL stray_done: got row_done %0b frame_done %0b expected 0 without write", row_done, frame_done);
        end
    end

    initial begin
        rst = 1'b1; start = 1'b0; cfg_w = '0; cfg_h = '0; cfg_base = '0;
        push = '0; din = '0;
        repeat (3) tick();
        check("rst_wr_en", wr_en, 0);
        check("rst_addr", wr_addr, 0);
        check("rst_data", wr_data, 0);
        check("rst_busy", busy, 0);
        check("rst_ready", ob_ready, 0);
        check("rst_overflow", overflow, 0);
        rst = 1'b0;
        tick();

        // Basic skewed wavefront, W=4 H=2
        do_start(4, 2, 16'h100);
        for (int r = 0; r < 2; r++)
            for (int c = 0; c < 4; c++)
                expect_wr(16'(16'h100 + r*4 + c), 32'((r == 0 ? 10 : 20) + c), c == 3, (r == 1) && (c == 3));
        check("busy_drain", busy, 1);
        check("ready_drain", ob_ready, 1);
        for (int k = 0; k < 5; k++) begin
            for (int i = 0; i < 4; i++)
                if (k - i >= 0 && k - i < 2) set_col(i, 32'((k - i == 0 ? 10 : 20) + i));
            fire();
        end
        wait_idle("basic_idle");

        // Stall at column 1 while column 0 runs ahead
        do_start(3, 3, 16'h0);
        for (int r = 0; r < 3; r++)
            for (int c = 0; c < 3; c++)
                expect_wr(16'(r*3 + c), 32'(32'h300 + r*16 + c), c == 2, (r == 2) && (c == 2));
        wr_mark = n_wr;
        for (int r = 0; r < 3; r++) begin
            set_col(0, 32'(32'h300 + r*16));
            fire();
        end
        repeat (6) tick();
        check("stall_writes", n_wr - wr_mark, 1);
        check("stall_busy", busy, 1);
        for (int r = 0; r < 3; r++) begin
            set_col(1, 32'(32'h300 + r*16 + 1));
            set_col(2, 32'(32'h300 + r*16 + 2));
            fire();
        end
        wait_idle("stall_idle");

        // Overflow on column 2 while drain waits at column 0
        do_start(3, 1, 16'h40);
        expect_wr(16'h40, 32'h60, 0, 0);
        expect_wr(16'h41, 32'h61, 0, 0);
        expect_wr(16'h42, 32'h50, 1, 1);
        for (int k = 0; k < 4; k++) begin
            set_col(2, 32'(32'h50 + k));
            fire();
        end
        check("full_ready", ob_ready, 0);
        check("full_no_overflow", overflow, 0);
        set_col(2, 32'h54);
        fire();
        check("overflow_set", overflow, 1);
        set_col(0, 32'h60);
        set_col(1, 32'h61);
        fire();
        wait_idle("ovf_idle");
        check("overflow_sticky", overflow, 1);

        // Push to a full FIFO in the same cycle it is popped
        do_start(2, 3, 16'h80);
        check("overflow_cleared", overflow, 0);
        expect_wr(16'h80, 32'hB0, 0, 0);
        expect_wr(16'h81, 32'hA0, 1, 0);
        expect_wr(16'h82, 32'hB1, 0, 0);
        expect_wr(16'h83, 32'hA1, 1, 0);
        expect_wr(16'h84, 32'hB2, 0, 0);
        expect_wr(16'h85, 32'hA2, 1, 1);
        for (int k = 0; k < 4; k++) begin
            set_col(1, 32'(32'hA0 + k));
            fire();
        end
        check("full1_ready", ob_ready, 0);
        set_col(0, 32'hB0);
        fire();
        tick();
        set_col(1, 32'hA4);
        fire();
        check("simul_no_overflow", overflow, 0);
        set_col(0, 32'hB1);
        fire();
        repeat (2) tick();
        set_col(0, 32'hB2);
        fire();
        wait_idle("simul_idle");

        // Out-of-range column, mid-frame start, zero-size start
        do_start(2, 1, 16'h200);
        wr_mark = n_wr;
        set_col(5, 32'hDEAD);
        fire();
        repeat (3) tick();
        check("col5_no_write", n_wr - wr_mark, 0);
        do_start(2, 2, 16'h500);
        expect_wr(16'h200, 32'h10, 0, 0);
        expect_wr(16'h201, 32'h11, 1, 1);
        set_col(0, 32'h10);
        set_col(1, 32'h11);
        fire();
        wait_idle("midstart_idle");
        do_start(0, 1, 16'h0);
        check("w0_idle", busy, 0);
        do_start(1, 0, 16'h0);
        check("h0_idle", busy, 0);

        // Reset in the middle of a row
        do_start(4, 1, 16'h20);
        expect_wr(16'h20, 32'h70, 0, 0);
        expect_wr(16'h21, 32'h71, 0, 0);
        set_col(0, 32'h70);
        set_col(1, 32'h71);
        fire();
        set_col(0, 32'h77);
        fire();
        repeat (3) tick();
        rst = 1'b1;
        tick();
        check("mrst_wr_en", wr_en, 0);
        check("mrst_addr", wr_addr, 0);
        check("mrst_data", wr_data, 0);
        check("mrst_busy", busy, 0);
        check("mrst_ready", ob_ready, 0);
        rst = 1'b0;
        tick();
        do_start(2, 1, 16'h30);
        expect_wr(16'h30, 32'h80, 0, 0);
        expect_wr(16'h31, 32'h81, 1, 1);
        set_col(0, 32'h80);
        set_col(1, 32'h81);
        fire();
        wait_idle("post_rst_idle");

        // Negative value through the write register
        do_start(2, 1, 16'h60);
`ifdef OB_RELU_EN
        expect_wr(16'h60, 32'h0, 0, 0);
`else
        expect_wr(16'h60, 32'hFFFF_FFFB, 0, 0);
`endif
        expect_wr(16'h61, 32'h7, 1, 1);
        set_col(0, 32'hFFFF_FFFB);
        set_col(1, 32'h7);
        fire();
        wait_idle("relu_idle");

        repeat (3) tick();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
